serial_subtractor: RTL and testbench

//   Bit-serial unsigned subtractor: computes diff = a - b, LSB first, one bit
//   per clock, with a single registered borrow. The per-bit step is the

---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// A single borrow flop carries between bit steps; diff/borrow are registered
// and only change at completion or reset.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_res_sr;
  logic               r_br;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;

  logic               w_accept;
  logic               w_step;
  logic               w_last;
  logic               w_ai;
  logic               w_bi;
  logic               w_d;
  logic               w_br_next;
  logic [WIDTH-1:0]   w_res_next;

  // Full-subtractor bit step on the current LSBs and the carried borrow.
  assign w_ai       = r_a_sr[0];
  assign w_bi       = r_b_sr[0];
  assign w_d        = w_ai ^ w_bi ^ r_br;
  assign w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_res_next = {w_d, r_res_sr[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and control decodes; start is only honoured outside BUSY.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_BUSY;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Serial datapath: load on accept, shift one bit per BUSY edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_res_sr <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_res_sr <= w_res_next;
      r_br     <= w_br_next;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Result registers: updated only when the final bit is processed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_last) begin
      r_diff   <= w_res_next;
      r_borrow <= w_br_next;
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random
// operand pairs compared against plain (WIDTH+1)-bit subtraction.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W:0] last_res;   // {borrow,diff} the outputs should be holding

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  // One isolated operation: accept, watch latency/holding, check result,
  // then confirm done drops when no new start is given.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
    logic [W:0] exp;
    int lat;
    bit got;
    exp = ref_sub(ta, tb_v);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);   // must be ignored while busy
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 3 * W) begin
      if ({borrow, diff} !== last_res) chk({tag, "_hold"}, 32'({borrow, diff}), 32'(last_res));
      if (done) chk({tag, "_early_done"}, 32'(done), 32'd0);
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"}, 32'(lat), 32'(W));
      chk({tag, "_diff"}, 32'(diff), 32'(exp[W-1:0]));
      chk({tag, "_borrow"}, 32'(borrow), 32'(exp[W]));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      last_res = {borrow, diff};
      @(posedge clk); #1;
      chk({tag, "_done_width"}, 32'(done), 32'd0);
    end
    $display("op %s: a=%02h b=%02h -> diff=%02h borrow=%0d latency=%0d", tag, ta, tb_v, diff, borrow, lat);
  endtask

  initial begin
    logic [W-1:0] sa [0:6];
    logic [W-1:0] sb [0:6];
    logic [W:0]   exp;
    int idx;
    int since_acc;
    bit acc_next;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    last_res = '0;

    // 1. Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) chk("idle_quiet", 32'({busy, done}), 32'd0);
    end
    $display("reset: busy=%0d done=%0d diff=%02h borrow=%0d", busy, done, diff, borrow);

    // 2-4. Directed values and corners
    do_op(8'd5, 8'd3, "5m3");
    do_op(8'd3, 8'd5, "3m5");
    do_op(8'h00, 8'h00, "0m0");
    do_op(8'hFF, 8'h01, "FFm01");
    do_op(8'h00, 8'hFF, "0mFF");

    // 5. start held high: back-to-back results every W+1 cycles
    for (int i = 0; i < 7; i++) begin
      sa[i] = W'($urandom);
      sb[i] = W'($urandom);
    end
    @(negedge clk);
    a = sa[0]; b = sa[0] ^ 8'h00; b = sb[0]; start = 1'b1;
    @(posedge clk); #1;
    a = W'($urandom); b = W'($urandom);
    idx = 0;
    since_acc = 0;
    acc_next = 1'b0;
    for (int cyc = 0; cyc < 200 && idx < 6; cyc++) begin
      @(posedge clk); #1;
      if (acc_next) begin
        since_acc = 0;
        acc_next = 1'b0;
        chk("b2b_done_clear", 32'(done), 32'd0);
        chk("b2b_busy_again", 32'(busy), 32'd1);
        a = W'($urandom); b = W'($urandom);
      end else begin
        since_acc++;
      end
      if (done) begin
        exp = ref_sub(sa[idx], sb[idx]);
        chk("b2b_interval", 32'(since_acc), 32'(W));
        chk("b2b_diff", 32'(diff), 32'(exp[W-1:0]));
        chk("b2b_borrow", 32'(borrow), 32'(exp[W]));
        $display("b2b %0d: a=%02h b=%02h -> diff=%02h borrow=%0d", idx, sa[idx], sb[idx], diff, borrow);
        last_res = {borrow, diff};
        idx++;
        a = sa[idx]; b = sb[idx];
        if (idx == 6) start = 1'b0;
        else acc_next = 1'b1;
      end else if (!acc_next && {borrow, diff} !== last_res) begin
        chk("b2b_hold", 32'({borrow, diff}), 32'(last_res));
      end
    end
    chk("b2b_count", 32'(idx), 32'd6);
    start = 1'b0;
    repeat (3) @(posedge clk);

    // 6. Reset during the 4th BUSY cycle
    @(negedge clk);
    a = 8'd9; b = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_borrow", 32'(borrow), 32'd0);
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) chk("mid_rst_quiet", 32'({busy, done}), 32'd0);
    end
    $display("reset mid-op: busy=%0d done=%0d diff=%02h borrow=%0d", busy, done, diff, borrow);
    last_res = '0;
    do_op(8'd9, 8'd4, "9m4");

    // Randomised operand pairs
    for (int i = 0; i < 1000; i++) begin
      do_op(W'($urandom), W'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
